// File: rtl/sw_select_debounced_pkg.sv
// Shared types and helpers for the debounced switch-to-index selector.
// The encoder works on a 32-bit vector so one function serves every N_SW.
package sw_pkg;

   localparam int ENC_W     = 32;
   localparam int ENC_IDX_W = 5;

   typedef struct packed {
      logic                 any;
      logic [ENC_IDX_W-1:0] idx;
   } enc_t;

   function automatic int idx_width(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

   // Later hits overwrite earlier ones, so the loop direction sets the winner.
   function automatic enc_t prio_enc(input logic [ENC_W-1:0] v, input logic lsb_first);
      enc_t r;
      r     = '0;
      r.any = |v;
      if (lsb_first) begin
         for (int i = ENC_W - 1; i >= 0; i--)
            if (v[i]) r.idx = ENC_IDX_W'(i);
      end else begin
         for (int i = 0; i < ENC_W; i++)
            if (v[i]) r.idx = ENC_IDX_W'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/sw_select_debounced_if.sv
// Switch bank in, selected index / LED image / status out.
interface sw_select_debounced_if
   import sw_pkg::*;
#(
   parameter int N_SW = 10
);
   localparam int IDX_W = idx_width(N_SW);

   logic [N_SW-1:0]  switches;
   logic [IDX_W-1:0] dec;
   logic [N_SW-1:0]  leds;
   logic             none;
   logic             changed;

   modport master (output switches, input dec, leds, none, changed);
   modport slave  (input switches, output dec, leds, none, changed);
endinterface

// File: rtl/sw_select_debounced_debounce.sv
// One switch: two-flop synchroniser, stability counter and debounced level.
// A level change is accepted after DEBOUNCE_CYCLES consecutive mismatching cycles.
module sw_debounce #(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic sw_raw,
   output logic db
);
   localparam int              CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_q1;
   logic             s_sync;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q1 <= 1'b0;
         s_sync  <= 1'b0;
         db      <= 1'b0;
         cnt     <= '0;
      end else begin
         sync_q1 <= sw_raw;
         s_sync  <= sync_q1;
         if (s_sync == db) begin
            cnt <= '0;
         end else if (cnt == CNT_TC) begin
            db  <= s_sync;
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end
endmodule

// File: rtl/sw_select_debounced.sv
// Debounced switch bank to registered priority-encoded index and one-hot LEDs.
// Flags "no switch on" and pulses changed when {dec, none} moves.
module sw_select_debounced
   import sw_pkg::*;
#(
   parameter int N_SW            = 10,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int LSB_PRIORITY    = 1,
   parameter int HOLD_ON_NONE    = 0
) (
   input  logic                   clk,
   input  logic                   reset,
   sw_select_debounced_if.slave   bus
);
   localparam int               IDX_W   = idx_width(N_SW);
   localparam logic [N_SW-1:0]  LED_ONE = N_SW'(1);

   logic [N_SW-1:0]  db;
   enc_t             enc;
   logic [IDX_W-1:0] dec_q,  dec_nxt;
   logic [N_SW-1:0]  leds_q, leds_nxt;
   logic             none_q, none_nxt;
   logic             changed_q;

   for (genvar i = 0; i < N_SW; i++) begin : g_db
      sw_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_db (
         .clk    (clk),
         .reset  (reset),
         .sw_raw (bus.switches[i]),
         .db     (db[i])
      );
   end

   // Only bits below N_SW can be set, so idx never reaches N_SW.
   always_comb begin
      enc      = prio_enc(ENC_W'(db), LSB_PRIORITY != 0);
      dec_nxt  = dec_q;
      none_nxt = 1'b1;
      leds_nxt = '0;
      if (enc.any) begin
         dec_nxt  = enc.idx[IDX_W-1:0];
         none_nxt = 1'b0;
         leds_nxt = LED_ONE << enc.idx;
      end else if (HOLD_ON_NONE == 0) begin
         dec_nxt  = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dec_q     <= '0;
         leds_q    <= '0;
         none_q    <= 1'b1;
         changed_q <= 1'b0;
      end else begin
         dec_q     <= dec_nxt;
         leds_q    <= leds_nxt;
         none_q    <= none_nxt;
         changed_q <= ({dec_nxt, none_nxt} != {dec_q, none_q});
      end
   end

   assign bus.dec     = dec_q;
   assign bus.leds    = leds_q;
   assign bus.none    = none_q;
   assign bus.changed = changed_q;
endmodule

// File: tb/tb_sw_select_debounced.sv
// Three selectors (LSB/clear, MSB/clear, LSB/hold) share one switch bank;
// each changed pulse is matched against a queued expected update.
module tb_sw_select_debounced;
   localparam int DC  = 4;
   localparam int LAT = DC + 3;

   typedef struct {
      int         cyc;
      logic [3:0] dec;
      logic [9:0] leds;
      logic       none;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [9:0] sw = '0;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   int         pulses [3] = '{0, 0, 0};
   exp_t       expq [3][$];

   sw_select_debounced_if #(.N_SW(10)) if_a ();
   sw_select_debounced_if #(.N_SW(10)) if_b ();
   sw_select_debounced_if #(.N_SW(10)) if_c ();

   assign if_a.switches = sw;
   assign if_b.switches = sw;
   assign if_c.switches = sw;

   sw_select_debounced #(.N_SW(10), .DEBOUNCE_CYCLES(DC), .LSB_PRIORITY(1), .HOLD_ON_NONE(0))
      dut_a (.clk(clk), .reset(reset), .bus(if_a));
   sw_select_debounced #(.N_SW(10), .DEBOUNCE_CYCLES(DC), .LSB_PRIORITY(0), .HOLD_ON_NONE(0))
      dut_b (.clk(clk), .reset(reset), .bus(if_b));
   sw_select_debounced #(.N_SW(10), .DEBOUNCE_CYCLES(DC), .LSB_PRIORITY(1), .HOLD_ON_NONE(1))
      dut_c (.clk(clk), .reset(reset), .bus(if_c));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int id, input int c, input logic [3:0] d, input logic [9:0] l,
                       input logic n);
      exp_t e;
      e.cyc  = c;
      e.dec  = d;
      e.leds = l;
      e.none = n;
      expq[id].push_back(e);
   endtask

   task automatic mon(input int id, input logic chg, input logic [3:0] d, input logic [9:0] l,
                      input logic n);
      exp_t e;
      if (chg === 1'b1) begin
         pulses[id]++;
         checks++;
         assert (expq[id].size() != 0) else begin
            errors++;
            $error("FAIL unexpected_changed dut%0d: observed dec=%0d none=%0b at cycle %0d expected no pulse",
                   id, d, n, cyc);
         end
         if (expq[id].size() != 0) begin
            e = expq[id].pop_front();
            check($sformatf("pulse_cycle dut%0d", id), cyc, e.cyc);
            check($sformatf("dec dut%0d", id), 32'(d), 32'(e.dec));
            check($sformatf("leds dut%0d", id), 32'(l), 32'(e.leds));
            check($sformatf("none dut%0d", id), 32'(n), 32'(e.none));
         end
      end
   endtask

   task automatic state(input string tag, input int id, input logic [3:0] d, input logic [9:0] l,
                        input logic n, input logic [3:0] ed, input logic [9:0] el, input logic en);
      check($sformatf("%s dec dut%0d", tag, id), 32'(d), 32'(ed));
      check($sformatf("%s leds dut%0d", tag, id), 32'(l), 32'(el));
      check($sformatf("%s none dut%0d", tag, id), 32'(n), 32'(en));
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         mon(0, if_a.changed, if_a.dec, if_a.leds, if_a.none);
         mon(1, if_b.changed, if_b.dec, if_b.leds, if_b.none);
         mon(2, if_c.changed, if_c.dec, if_c.leds, if_c.none);
      end
   end

   initial begin
      int c;

      // reset values
      repeat (3) @(negedge clk);
      state("reset", 0, if_a.dec, if_a.leds, if_a.none, 4'd0, 10'h000, 1'b1);
      state("reset", 1, if_b.dec, if_b.leds, if_b.none, 4'd0, 10'h000, 1'b1);
      state("reset", 2, if_c.dec, if_c.leds, if_c.none, 4'd0, 10'h000, 1'b1);
      check("reset changed dut0", 32'(if_a.changed), 32'd0);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      state("idle", 0, if_a.dec, if_a.leds, if_a.none, 4'd0, 10'h000, 1'b1);
      state("idle", 2, if_c.dec, if_c.leds, if_c.none, 4'd0, 10'h000, 1'b1);

      // bits 3 and 5 on: priority rule decides
      sw = 10'b0000101000;
      c = cyc;
      push(0, c + LAT, 4'd3, 10'h008, 1'b0);
      push(1, c + LAT, 4'd5, 10'h020, 1'b0);
      push(2, c + LAT, 4'd3, 10'h008, 1'b0);
      repeat (12) @(negedge clk);

      // 3-cycle glitch on bit 7 must be ignored
      sw = 10'b0010101000;
      repeat (3) @(negedge clk);
      sw = 10'b0000101000;
      repeat (12) @(negedge clk);
      state("glitch", 1, if_b.dec, if_b.leds, if_b.none, 4'd5, 10'h020, 1'b0);

      // 4-cycle pulse on bit 7 is accepted, then released
      sw = 10'b0010101000;
      c = cyc;
      push(1, c + LAT, 4'd7, 10'h080, 1'b0);
      push(1, c + 4 + LAT, 4'd5, 10'h020, 1'b0);
      repeat (4) @(negedge clk);
      sw = 10'b0000101000;
      repeat (12) @(negedge clk);

      // swap to bit 9 only: simultaneous db flips give a single update
      sw = 10'b1000000000;
      c = cyc;
      push(0, c + LAT, 4'd9, 10'h200, 1'b0);
      push(1, c + LAT, 4'd9, 10'h200, 1'b0);
      push(2, c + LAT, 4'd9, 10'h200, 1'b0);
      repeat (12) @(negedge clk);

      // all off: clear vs hold of dec
      sw = 10'b0000000000;
      c = cyc;
      push(0, c + LAT, 4'd0, 10'h000, 1'b1);
      push(1, c + LAT, 4'd0, 10'h000, 1'b1);
      push(2, c + LAT, 4'd9, 10'h000, 1'b1);
      repeat (12) @(negedge clk);
      state("hold", 2, if_c.dec, if_c.leds, if_c.none, 4'd9, 10'h000, 1'b1);

      // reset mid-count discards the partial count
      sw = 10'b0000000100;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      state("midreset", 2, if_c.dec, if_c.leds, if_c.none, 4'd0, 10'h000, 1'b1);
      @(negedge clk);
      reset = 1'b0;
      c = cyc;
      push(0, c + LAT, 4'd2, 10'h004, 1'b0);
      push(1, c + LAT, 4'd2, 10'h004, 1'b0);
      push(2, c + LAT, 4'd2, 10'h004, 1'b0);
      repeat (12) @(negedge clk);

      for (int i = 0; i < 3; i++)
         check($sformatf("pending_updates dut%0d", i), expq[i].size(), 0);
      check("pulse_count dut0", pulses[0], 4);
      check("pulse_count dut1", pulses[1], 6);
      check("pulse_count dut2", pulses[2], 4);
      state("final", 0, if_a.dec, if_a.leds, if_a.none, 4'd2, 10'h004, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      errors++;
      $display("FAIL timeout: observed no completion expected finish before 100000");
      $fatal(1, "timeout");
   end
endmodule
